// File: rtl/ads8681_pkg.sv
// Shared types and constants for the ADS8681 acquisition front end.
package ads8681_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        READ = 2'd2,
        ACQ  = 2'd3
    } state_t;

    localparam int SAMPLE_BITS = 16;
    localparam int SEQ_BITS    = 16;
    localparam int WORD_BITS   = 32;

    // 100 MHz defaults: 1 us conversion, 25 MHz SCLK, 350 ns acquisition.
    localparam int DEF_CLK_DIV     = 2;
    localparam int DEF_CONV_CYCLES = 100;
    localparam int DEF_ACQ_CYCLES  = 35;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ads8681_acq_ctrl_if.sv
// Word stream from the ADC front end towards the PSSI packer.
interface ads8681_acq_ctrl_if;
    import ads8681_pkg::*;

    // A word moves on every cycle where valid_o and ready_i are both high;
    // while valid_o is high and ready_i low, data_o is held unchanged.
    logic [WORD_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i;

    modport master (output data_o, output valid_o, input ready_i);
    modport slave  (input data_o, input valid_o, output ready_i);

endinterface

// File: rtl/ads8681_spi_rx.sv
// SCLK generator and MSB-first 16-bit shift-in for one ADS8681 read frame.
module ads8681_spi_rx
    import ads8681_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sdo,
    output logic                   sclk,
    output logic                   done,
    output logic [SAMPLE_BITS-1:0] sample
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(SAMPLE_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SAMPLE_BITS - 1);

    logic             active;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            done    <= 1'b0;
            sample  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                active  <= 1'b1;
                div_cnt <= '0;
                bit_cnt <= '0;
                sclk    <= 1'b0;
            end else if (active) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    sclk    <= ~sclk;
                    // Data is taken on the same clock that drives SCLK high.
                    if (!sclk) begin
                        sample <= {sample[SAMPLE_BITS-2:0], sdo};
                        done   <= (bit_cnt == BIT_LAST);
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) active <= 1'b0;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ads8681_acq_ctrl.sv
// ADS8681 acquisition controller: conversion/read/acquire sequencing, sequence
// numbering and a one-word output register with sticky overrun.
module ads8681_acq_ctrl
    import ads8681_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int CONV_CYCLES = DEF_CONV_CYCLES,
    parameter int ACQ_CYCLES  = DEF_ACQ_CYCLES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               clear_i,
    output logic               adc_convst_o,
    output logic               adc_sclk_o,
    input  logic               adc_sdo_i,
    ads8681_acq_ctrl_if.master bus,
    output logic               overrun_o,
    output logic               busy_o,
    output state_t             state_o
);

    localparam int CNT_W = $clog2(max3(CONV_CYCLES, 32 * CLK_DIV, ACQ_CYCLES) + 1);
    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(32 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] ACQ_LAST  = CNT_W'(ACQ_CYCLES - 1);

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt;
    logic                   convst_q, busy_q;
    logic                   spi_start, spi_done;
    logic [SAMPLE_BITS-1:0] sample;
    logic [SEQ_BITS-1:0]    seq;
    logic [WORD_BITS-1:0]   data_q;
    logic                   valid_q, overrun_q;

    ads8681_spi_rx #(.CLK_DIV(CLK_DIV)) u_spi_rx (
        .clk    (clk_i),
        .rst    (rst_i),
        .start  (spi_start),
        .sdo    (adc_sdo_i),
        .sclk   (adc_sclk_o),
        .done   (spi_done),
        .sample (sample)
    );

    always_comb begin
        state_n   = state;
        spi_start = 1'b0;
        unique case (state)
            IDLE: if (enable_i) state_n = CONV;
            CONV: if (cnt == CONV_LAST) begin
                state_n   = READ;
                spi_start = 1'b1;
            end
            READ: if (cnt == READ_LAST) state_n = ACQ;
            ACQ:  if (cnt == ACQ_LAST) state_n = enable_i ? CONV : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // One timer serves all phases; it restarts on every state change.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            convst_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
            convst_q <= (state_n == CONV);
            busy_q   <= (state_n != IDLE);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seq       <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (spi_done) begin
                // A held word not taken this cycle wins; the new sample is dropped.
                if (!valid_q || bus.ready_i) begin
                    data_q  <= {seq, sample};
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
                seq <= seq + 1'b1;
            end else if (valid_q && bus.ready_i) begin
                valid_q <= 1'b0;
            end
            if (clear_i) begin
                seq       <= '0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign adc_convst_o = convst_q;
    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;
    assign bus.data_o   = data_q;
    assign bus.valid_o  = valid_q;
    assign state_o      = state;

endmodule

// File: tb/tb_ads8681_acq_ctrl.sv
// Bench for ads8681_acq_ctrl: ADC serial model, frame-position reference model
// with per-cycle compare, accepted-word scoreboard and directed scenarios.
module tb_ads8681_acq_ctrl;
    import ads8681_pkg::*;

    localparam int DIV      = 2;
    localparam int CONV_C   = 10;
    localparam int ACQ_C    = 4;
    localparam int FRAME    = CONV_C + 32 * DIV + ACQ_C;
    localparam int LOAD_POS = CONV_C + 31 * DIV;

    logic   clk = 1'b0;
    logic   rst, enable, clear, ready;
    logic   convst, sclk, sdo, overrun, busy;
    state_t dbg_state;

    ads8681_acq_ctrl_if acq_bus ();
    assign acq_bus.ready_i = ready;

    ads8681_acq_ctrl #(.CLK_DIV(DIV), .CONV_CYCLES(CONV_C), .ACQ_CYCLES(ACQ_C)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .clear_i      (clear),
        .adc_convst_o (convst),
        .adc_sclk_o   (sclk),
        .adc_sdo_i    (sdo),
        .bus          (acq_bus),
        .overrun_o    (overrun),
        .busy_o       (busy),
        .state_o      (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ADC: MSB valid once CONVST falls, next bit after each SCLK rise.
    logic [15:0] adc_words[$];
    logic [15:0] cur_word = '0;
    int          bit_idx  = -1;

    always @(posedge convst) begin
        if (adc_words.size() > 0) cur_word = adc_words.pop_front();
        else cur_word = 16'($urandom_range(0, 65535));
        bit_idx = 15;
    end
    always @(posedge sclk) bit_idx = bit_idx - 1;
    assign sdo = (bit_idx >= 0) ? cur_word[bit_idx[3:0]] : 1'b0;

    // Reference model: position inside the frame plus the output register rules.
    bit          running   = 1'b0;
    int          pos       = 0;
    bit          m_valid   = 1'b0;
    bit          m_overrun = 1'b0;
    logic [31:0] m_data    = '0;
    logic [15:0] m_seq     = '0;
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            running = 1'b0; pos = 0; m_valid = 1'b0; m_overrun = 1'b0;
            m_data = '0; m_seq = '0; exp_q.delete();
        end else begin
            if (m_valid && ready) exp_q.push_back(m_data);
            if (running && pos == LOAD_POS) begin
                if (!m_valid || ready) begin
                    m_data = {m_seq, cur_word};
                    m_valid = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
                m_seq = m_seq + 16'd1;
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
            if (clear) begin
                m_seq = '0;
                m_overrun = 1'b0;
            end
            if (running) begin
                if (pos == FRAME - 1) begin
                    if (enable) pos = 0;
                    else running = 1'b0;
                end else begin
                    pos++;
                end
            end else if (enable) begin
                running = 1'b1;
                pos = 0;
            end
        end
    end

    bit e_conv, e_sclk;
    always @(negedge clk) begin
        e_conv = running && pos < CONV_C;
        e_sclk = running && pos >= CONV_C && pos < CONV_C + 32 * DIV && (((pos - CONV_C) / DIV) % 2 == 1);
        chk("convst", 32'(convst), 32'(e_conv));
        chk("sclk", 32'(sclk), 32'(e_sclk));
        chk("busy", 32'(busy), 32'(running));
        chk("valid", 32'(acq_bus.valid_o), 32'(m_valid));
        chk("data", acq_bus.data_o, m_data);
        chk("overrun", 32'(overrun), 32'(m_overrun));
    end

    // Event monitor (timestamps, accepted words) and scoreboard.
    int          conv_rise_q[$], conv_fall_q[$], sclk_rise_q[$], vrun_q[$];
    logic [31:0] acc_q[$];
    logic        prev_convst = 1'b0, prev_sclk = 1'b0;
    int          vrun = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_data = '0;

    always @(negedge clk) begin
        if (convst && !prev_convst) conv_rise_q.push_back(cyc);
        if (!convst && prev_convst) conv_fall_q.push_back(cyc);
        if (sclk && !prev_sclk) sclk_rise_q.push_back(cyc);
        prev_convst = convst;
        prev_sclk   = sclk;
        if (acq_bus.valid_o) vrun++;
        else if (vrun > 0) begin
            vrun_q.push_back(vrun);
            vrun = 0;
        end
        if (rst) pend = 1'b0;
        else if (pend) begin
            chk("sb_depth", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("sb_word", pend_data, exp_q.pop_front());
            pend = 1'b0;
        end
        if (acq_bus.valid_o && ready && !rst) begin
            acc_q.push_back(acq_bus.data_o);
            pend = 1'b1;
            pend_data = acq_bus.data_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        conv_rise_q.delete(); conv_fall_q.delete(); sclk_rise_q.delete();
        vrun_q.delete(); acc_q.delete();
    endtask

    task automatic wait_rises(input int n, input int budget);
        int k = 0;
        while (conv_rise_q.size() < n && k < budget) begin @(negedge clk); #1; k++; end
        chk("wait_rises", 32'(conv_rise_q.size() >= n), 32'd1);
    endtask

    task automatic wait_sclk(input int n, input int budget);
        int k = 0;
        while (sclk_rise_q.size() < n && k < budget) begin @(negedge clk); #1; k++; end
        chk("wait_sclk", 32'(sclk_rise_q.size() >= n), 32'd1);
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while (acc_q.size() < n && k < budget) begin @(negedge clk); #1; k++; end
        chk("wait_acc", 32'(acc_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        do begin @(negedge clk); #1; k++; end while ((busy || acq_bus.valid_o) && k < budget);
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic test_single_frame();
        int n = 0;
        clear_logs();
        adc_words.push_back(16'hA55A);
        adc_words.push_back(16'h5AA5);
        step(); ready = 1'b1; enable = 1'b1;
        wait_rises(2, 300);
        step(); enable = 1'b0;   // dropped inside the second CONV
        wait_idle(300);
        chk("a_period", conv_rise_q[1] - conv_rise_q[0], 78);
        chk("a_conv_len", conv_fall_q[0] - conv_rise_q[0], 10);
        foreach (sclk_rise_q[i]) if (sclk_rise_q[i] < conv_rise_q[1]) n++;
        chk("a_sclk_count", n, 16);
        chk("a_first_rise", sclk_rise_q[0] - conv_fall_q[0], DIV);
        chk("a_sclk_period", sclk_rise_q[1] - sclk_rise_q[0], 4);
        chk("a_sclk_span", sclk_rise_q[15] - sclk_rise_q[0], 60);
        chk("a_words", acc_q.size(), 2);
        chk("a_word0", acc_q[0], 32'h0000A55A);
        chk("a_word1", acc_q[1], 32'h00015AA5);
        chk("a_valid_len", vrun_q[0], 1);
        repeat (100) @(negedge clk);
        #1;
        chk("a_no_restart", conv_rise_q.size(), 2);
        chk("a_idle_convst", 32'(convst), 32'd0);
        chk("a_idle_state", 32'(dbg_state), 32'(IDLE));
    endtask

    task automatic test_reset_mid_read();
        clear_logs();
        adc_words.push_back(16'h1357);
        adc_words.push_back(16'h2468);
        step(); ready = 1'b1; enable = 1'b1;
        wait_sclk(8, 300);
        #1 rst = 1'b1;
        #1;
        chk("d_convst", 32'(convst), 32'd0);
        chk("d_sclk", 32'(sclk), 32'd0);
        chk("d_valid", 32'(acq_bus.valid_o), 32'd0);
        chk("d_busy", 32'(busy), 32'd0);
        chk("d_data", acq_bus.data_o, 32'd0);
        step(); rst = 1'b0;
        wait_acc(1, 300);
        chk("d_first_word", acc_q[0], 32'h00002468);
        step(); enable = 1'b0;
        wait_idle(300);
    endtask

    task automatic test_overrun();
        logic [31:0] w;
        clear_logs();
        step(); clear = 1'b1;
        step(); clear = 1'b0;
        adc_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        ready = 1'b0; enable = 1'b1;
        wait_rises(4, 400);
        chk("b_hold_data", acq_bus.data_o, 32'h00001111);
        chk("b_hold_valid", 32'(acq_bus.valid_o), 32'd1);
        chk("b_overrun", 32'(overrun), 32'd1);
        step(); ready = 1'b1;
        wait_rises(5, 200);
        step(); clear = 1'b1;
        step(); clear = 1'b0; enable = 1'b0;
        chk("b_overrun_clr", 32'(overrun), 32'd0);
        wait_idle(300);
        chk("b_words", acc_q.size(), 3);
        chk("b_word0", acc_q[0], 32'h00001111);
        chk("b_word1", acc_q[1], 32'h00034444);
        w = acc_q[2];
        chk("b_word2", w, 32'h00005555);
    endtask

    task automatic test_random();
        clear_logs();
        for (int c = 0; c < 4000; c++) begin
            step();
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 299) == 0);
        end
        step(); enable = 1'b0; clear = 1'b0; ready = 1'b1;
        wait_idle(400);
    endtask

    task automatic test_seq_wrap();
        logic [31:0] w;
        clear_logs();
        step();
        force dut.seq = 16'hFFFE;
        m_seq = 16'hFFFE;
        #1 release dut.seq;
        step(); ready = 1'b1; enable = 1'b1;
        wait_rises(3, 300);
        step(); enable = 1'b0;
        wait_idle(300);
        chk("e_words", acc_q.size(), 3);
        w = acc_q[0]; chk("e_seq0", 32'(w[31:16]), 32'h0000FFFE);
        w = acc_q[1]; chk("e_seq1", 32'(w[31:16]), 32'h0000FFFF);
        w = acc_q[2]; chk("e_seq2", 32'(w[31:16]), 32'h00000000);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_convst", 32'(convst), 32'd0);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_valid", 32'(acq_bus.valid_o), 32'd0);
        chk("rst_data", acq_bus.data_o, 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        step(); rst = 1'b0;
        repeat (3) step();
        test_single_frame();
        test_reset_mid_read();
        test_overrun();
        test_random();
        test_seq_wrap();
        repeat (5) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
